alarm_set_ctrl: RTL
===================

Name: alarm_set_ctrl

Overview:
- User-interface sequencer for the alarm clock block. Turns three single-cycle button pulses (Mode/Enter/Inc) into field-by-field editing of the time and alarm values.
- Issues one-cycle LoadTime / LoadAlm strobes, with the load buses valid in the same cycle.
- Sits between the debounced button logic and alarm_clk, and runs on the same clock.

Parameters:
- TIMEOUT_CYC, 30: idle cycles in any edit state before the edit is abandoned; legal range 2..255.
- SNOOZE_MIN, 5: minutes added per snooze; legal range 1..59; used only with SNOOZE_EN.

Ports:
- Clock_1Sec in 1: clock; all state changes on its rising edge.
- Reset in 1: asynchronous, active-high reset.
- ModeBtn in 1: one-cycle pulse; enter or switch edit mode.
- EnterBtn in 1: one-cycle pulse; confirm the current field.
- IncBtn in 1: one-cycle pulse; increment the current field.
- Cur_Hours in 4: current hours from alarm_clk, 1..12.
- Cur_Mins in 6: current minutes from alarm_clk, 0..59.
- Cur_AM_PM in 1: current AM/PM from alarm_clk; 0 = AM.
- SetSecs out 6: time load seconds; constant 0.
- SetMins out 6: time load minutes (edit buffer).
- SetHours out 4: time load hours (edit buffer).
- Set_AM_PM out 1: time load AM/PM (edit buffer).
- LoadTime out 1: one-cycle time load strobe.
- AlarmMinsIn out 6: alarm shadow minutes.
- AlarmHoursIn out 4: alarm shadow hours.
- Alarm_AM_PM_In out 1: alarm shadow AM/PM.
- LoadAlm out 1: one-cycle alarm load strobe.
- EditActive out 1: high in every state except IDLE.
- EditField out 2: 0 = none, 1 = hours, 2 = mins, 3 = AM/PM.

Behaviour:
- Reset (asynchronous, Reset=1):
  - State = IDLE.
  - Edit buffer = 12:00 AM.
  - Alarm shadow = 12:00 AM.
  - LoadTime = LoadAlm = 0, EditActive = 0, EditField = 0, timeout counter = 0.
  - Reset asserted mid-edit discards the edit and issues no load.
- States: IDLE, T_HOUR, T_MIN, T_AMPM, T_COMMIT, A_HOUR, A_MIN, A_AMPM, A_COMMIT.
- Button priority in the same cycle: Mode > Enter > Inc. Lower-priority pulses in that cycle are ignored.
- IDLE:
  - ModeBtn -> T_HOUR; edit buffer loaded from Cur_Hours / Cur_Mins / Cur_AM_PM.
  - Enter and Inc are ignored.
- Any T_* state:
  - ModeBtn -> A_HOUR; time edit abandoned; edit buffer loaded from the alarm shadow.
- Any A_* state:
  - ModeBtn -> IDLE; edit abandoned; no load.
- EnterBtn advances the field:
  - HOUR -> MIN -> AMPM -> COMMIT.
- IncBtn acts on the current field only:
  - Hours: 1..12; 12 wraps to 1.
  - Mins: 0..59; 59 wraps to 0.
  - AM/PM: toggles.
  - Field changes are visible on the outputs the next cycle.
- T_COMMIT (exactly one cycle):
  - LoadTime = 1; SetHours / SetMins / Set_AM_PM = edit buffer; SetSecs = 0.
  - Next state IDLE.
  - Latency: Enter in T_AMPM at edge N gives LoadTime high in cycle N+1.
- A_COMMIT (exactly one cycle):
  - Alarm shadow <= edit buffer on the edge entering A_COMMIT.
  - LoadAlm = 1 in the same cycle, so the Alarm* outputs already show the new values.
  - Next state IDLE.
- Button presses during a COMMIT cycle are ignored.
- Timeout:
  - Counter clears on any button pulse or state change.
  - Increments every cycle in the HOUR / MIN / AMPM states.
  - When it reaches TIMEOUT_CYC-1 -> IDLE; no load; alarm shadow unchanged.
- Outside edits, Set* outputs hold the last edit-buffer value. Alarm* outputs always hold the shadow.
- LoadTime and LoadAlm are never high simultaneously and never high for two consecutive cycles.

Optional Feature:
- Macro: SNOOZE_EN.
- Defined:
  - Adds input ports Alarm (1, ringing indicator from alarm_clk) and SnoozeBtn (1, one-cycle pulse).
  - In IDLE, SnoozeBtn while Alarm=1 adds SNOOZE_MIN to the alarm shadow and pulses LoadAlm the next cycle. The state is entered as A_COMMIT-equivalent, with EditActive held 0.
  - Minutes >= 60: subtract 60 and increment hours.
  - Hours 11 -> 12 toggles AM/PM; hours 12 -> 1 leaves AM/PM unchanged.
  - SnoozeBtn is ignored outside IDLE, or when Alarm=0.
- Undefined: neither port exists; no snooze logic.

Test Plan:
- Reset mid-edit: Mode, Inc, then Reset=1 -> all outputs at reset values; Alarm* = 12:00 AM; no LoadTime or LoadAlm pulse.
- Time set: Cur = 11:59 AM; Mode, Inc (hours -> 12), Enter, Inc (mins -> 0), Enter, Inc (PM), Enter -> next cycle LoadTime=1 for one cycle; SetHours=12, SetMins=0, Set_AM_PM=1, SetSecs=0; state IDLE.
- Alarm set with wrap: Mode, Mode (alarm edit, buffer = 12:00 AM), Inc (hours -> 1), Enter, 59 Inc pulses (mins = 59), Inc (mins -> 0), Enter, Enter -> LoadAlm one cycle with AlarmHoursIn=1, AlarmMinsIn=0, Alarm_AM_PM_In=0.
- Priority and abandon: Mode+Enter+Inc in the same cycle while in T_MIN -> A_HOUR, buffer unchanged by Inc; then Mode -> IDLE, no load strobes.
- Timeout: TIMEOUT_CYC=30; Mode then no buttons -> IDLE after 30 cycles, EditActive falls, no load; shadow unchanged.
- SNOOZE_EN: shadow = 11:58 PM, Alarm=1, SnoozeBtn -> LoadAlm next cycle with 12:03 AM; Alarm=0, SnoozeBtn -> no effect.

Source files
------------

// File: rtl/alarm_set_ctrl.sv
// Button-driven editor for the alarm clock's time and alarm values; emits one-cycle load strobes.
// Optional snooze support is compiled in when the SNOOZE_EN macro is defined.
module alarm_set_ctrl #(
  parameter int TIMEOUT_CYC = 30,
  parameter int SNOOZE_MIN  = 5
) (
  input  logic       Clock_1Sec,
  input  logic       Reset,
  input  logic       ModeBtn,
  input  logic       EnterBtn,
  input  logic       IncBtn,
`ifdef SNOOZE_EN
  input  logic       Alarm,
  input  logic       SnoozeBtn,
`endif
  input  logic [3:0] Cur_Hours,
  input  logic [5:0] Cur_Mins,
  input  logic       Cur_AM_PM,
  output logic [5:0] SetSecs,
  output logic [5:0] SetMins,
  output logic [3:0] SetHours,
  output logic       Set_AM_PM,
  output logic       LoadTime,
  output logic [5:0] AlarmMinsIn,
  output logic [3:0] AlarmHoursIn,
  output logic       Alarm_AM_PM_In,
  output logic       LoadAlm,
  output logic       EditActive,
  output logic [1:0] EditField
);

  typedef enum logic [3:0] {
    IDLE, T_HOUR, T_MIN, T_AMPM, T_COMMIT, A_HOUR, A_MIN, A_AMPM, A_COMMIT, S_COMMIT
  } state_t;

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYC out of range 2..255");
  end
  if (SNOOZE_MIN < 1 || SNOOZE_MIN > 59) begin : g_bad_snooze
    $error("SNOOZE_MIN out of range 1..59");
  end

  state_t      state_q, state_d;
  logic [3:0]  hrs_q, hrs_d, al_hrs_q, al_hrs_d;
  logic [5:0]  min_q, min_d, al_min_q, al_min_d;
  logic        ampm_q, ampm_d, al_ampm_q, al_ampm_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        load_time_q, load_alm_q, edit_active_q;
  logic [1:0]  edit_field_q;
  logic        any_btn;

  function automatic logic [1:0] field_of(input state_t s);
    case (s)
      T_HOUR, A_HOUR: field_of = 2'd1;
      T_MIN,  A_MIN:  field_of = 2'd2;
      T_AMPM, A_AMPM: field_of = 2'd3;
      default:        field_of = 2'd0;
    endcase
  endfunction

  assign any_btn = ModeBtn | EnterBtn | IncBtn;

`ifdef SNOOZE_EN
  logic [6:0] snz_sum;
  assign snz_sum = {1'b0, al_min_q} + 7'(SNOOZE_MIN);
`endif

  always_comb begin
    state_d   = state_q;
    hrs_d     = hrs_q;
    min_d     = min_q;
    ampm_d    = ampm_q;
    al_hrs_d  = al_hrs_q;
    al_min_d  = al_min_q;
    al_ampm_d = al_ampm_q;
    case (state_q)
      IDLE: begin
        if (ModeBtn) begin
          state_d = T_HOUR;
          hrs_d   = Cur_Hours;
          min_d   = Cur_Mins;
          ampm_d  = Cur_AM_PM;
        end
`ifdef SNOOZE_EN
        else if (SnoozeBtn && Alarm) begin
          state_d = S_COMMIT;
          if (snz_sum >= 7'd60) begin
            al_min_d = 6'(snz_sum - 7'd60);
            // 11 -> 12 crosses noon/midnight; 12 -> 1 does not
            if (al_hrs_q == 4'd11) begin
              al_hrs_d  = 4'd12;
              al_ampm_d = ~al_ampm_q;
            end else if (al_hrs_q >= 4'd12) begin
              al_hrs_d = 4'd1;
            end else begin
              al_hrs_d = al_hrs_q + 4'd1;
            end
          end else begin
            al_min_d = snz_sum[5:0];
          end
        end
`endif
      end
      T_COMMIT, A_COMMIT, S_COMMIT: state_d = IDLE;
      default: begin
        if (ModeBtn) begin
          if (state_q inside {T_HOUR, T_MIN, T_AMPM}) begin
            state_d = A_HOUR;
            hrs_d   = al_hrs_q;
            min_d   = al_min_q;
            ampm_d  = al_ampm_q;
          end else begin
            state_d = IDLE;
          end
        end else if (EnterBtn) begin
          case (state_q)
            T_HOUR:  state_d = T_MIN;
            T_MIN:   state_d = T_AMPM;
            T_AMPM:  state_d = T_COMMIT;
            A_HOUR:  state_d = A_MIN;
            A_MIN:   state_d = A_AMPM;
            default: begin
              // shadow updates on entry so LoadAlm and Alarm* line up
              state_d   = A_COMMIT;
              al_hrs_d  = hrs_q;
              al_min_d  = min_q;
              al_ampm_d = ampm_q;
            end
          endcase
        end else if (IncBtn) begin
          case (edit_field_q)
            2'd1:    hrs_d  = (hrs_q >= 4'd12) ? 4'd1 : hrs_q + 4'd1;
            2'd2:    min_d  = (min_q >= 6'd59) ? 6'd0 : min_q + 6'd1;
            default: ampm_d = ~ampm_q;
          endcase
        end else if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
          state_d = IDLE;
        end
      end
    endcase

    if (any_btn || state_d != state_q || field_of(state_q) == 2'd0) cnt_d = 8'd0;
    else                                                            cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge Clock_1Sec or posedge Reset) begin
    if (Reset) begin
      state_q       <= IDLE;
      hrs_q         <= 4'd12;
      min_q         <= 6'd0;
      ampm_q        <= 1'b0;
      al_hrs_q      <= 4'd12;
      al_min_q      <= 6'd0;
      al_ampm_q     <= 1'b0;
      cnt_q         <= 8'd0;
      load_time_q   <= 1'b0;
      load_alm_q    <= 1'b0;
      edit_active_q <= 1'b0;
      edit_field_q  <= 2'd0;
    end else begin
      state_q       <= state_d;
      hrs_q         <= hrs_d;
      min_q         <= min_d;
      ampm_q        <= ampm_d;
      al_hrs_q      <= al_hrs_d;
      al_min_q      <= al_min_d;
      al_ampm_q     <= al_ampm_d;
      cnt_q         <= cnt_d;
      load_time_q   <= (state_d == T_COMMIT);
      load_alm_q    <= (state_d == A_COMMIT) || (state_d == S_COMMIT);
      edit_active_q <= (state_d != IDLE) && (state_d != S_COMMIT);
      edit_field_q  <= field_of(state_d);
    end
  end

  assign SetSecs        = 6'd0;
  assign SetMins        = min_q;
  assign SetHours       = hrs_q;
  assign Set_AM_PM      = ampm_q;
  assign LoadTime       = load_time_q;
  assign AlarmMinsIn    = al_min_q;
  assign AlarmHoursIn   = al_hrs_q;
  assign Alarm_AM_PM_In = al_ampm_q;
  assign LoadAlm        = load_alm_q;
  assign EditActive     = edit_active_q;
  assign EditField      = edit_field_q;

endmodule
